// File: rtl/led_shift_history_pkg.sv
// Shared defaults and width helpers for the LED shift/undo display block.
package led_shift_pkg;

  localparam int unsigned DEF_WIDTH = 18;
  localparam int unsigned DEF_SYM_W = 1;
  localparam int unsigned DEF_DEPTH = 4;

  // Bits needed to hold a history count of 0..depth inclusive.
  function automatic int unsigned CNT_W(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Ring pointer width; at least one bit so DEPTH=1 still has a legal vector.
  function automatic int unsigned PTR_W(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/led_shift_history_if.sv
// Command and status bundle between the symbol decoder and the LED shift register.
interface led_shift_history_if
  import led_shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SYM_W = DEF_SYM_W,
  parameter int unsigned DEPTH = DEF_DEPTH
);
  logic                    shift_en;
  logic [SYM_W-1:0]        din;
  logic                    undo_en;
  logic                    clear;
  logic [WIDTH-1:0]        led;
  logic [CNT_W(DEPTH)-1:0] hist_count;
  logic                    hist_empty;
  logic                    hist_full;
  logic                    undo_err;

  modport master (
    output shift_en, din, undo_en, clear,
    input  led, hist_count, hist_empty, hist_full, undo_err
  );

  modport slave (
    input  shift_en, din, undo_en, clear,
    output led, hist_count, hist_empty, hist_full, undo_err
  );
endinterface

// File: rtl/led_hist_lifo.sv
// WIDTH x DEPTH ring-buffer LIFO; a push when full overwrites the oldest entry.
module led_hist_lifo
  import led_shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                    clk1,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        top,
  output logic [CNT_W(DEPTH)-1:0] count,
  output logic                    empty,
  output logic                    full
);
  localparam int unsigned CW = CNT_W(DEPTH);
  localparam int unsigned PW = PTR_W(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_inc;
  logic [PW-1:0]    ptr_dec;
  logic             do_pop;
  logic             do_push;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    ptr_inc = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    ptr_dec = (ptr == '0) ? PW'(DEPTH - 1) : ptr - 1'b1;
    // flush > pop > push, so at most one of these is ever active
    do_pop  = pop & ~flush & ~empty;
    do_push = push & ~flush & ~pop;
    top     = mem[ptr];
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (flush) begin
      ptr   <= '0;
      count <= '0;
    end else if (do_pop) begin
      ptr   <= ptr_dec;
      count <= count - 1'b1;
    end else if (do_push) begin
      ptr <= ptr_inc;
      if (!full) count <= count + 1'b1;
    end
  end

  // Entry contents carry no reset; only ptr/count define validity.
  always_ff @(posedge clk1) begin
    if (do_push) mem[ptr_inc] <= din;
  end
endmodule

// File: rtl/led_shift_history.sv
// LED shift register with multi-level undo; clear > undo > shift on each edge.
module led_shift_history
  import led_shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SYM_W = DEF_SYM_W,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                clk1,
  input  logic                reset,
  led_shift_history_if.slave  bus
);
  logic [WIDTH-1:0]        led_q;
  logic                    undo_err_q;
  logic [WIDTH-1:0]        top;
  logic [CNT_W(DEPTH)-1:0] count;
  logic                    empty;
  logic                    full;
  logic                    do_clear;
  logic                    do_undo;
  logic                    do_shift;

  always_comb begin
    do_clear = bus.clear;
    do_undo  = bus.undo_en & ~bus.clear;
    do_shift = bus.shift_en & ~bus.undo_en & ~bus.clear;
  end

  led_hist_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_hist (
    .clk1  (clk1),
    .reset (reset),
    .push  (do_shift),
    .pop   (do_undo),
    .flush (do_clear),
    .din   (led_q),
    .top   (top),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      led_q      <= '0;
      undo_err_q <= 1'b0;
    end else begin
      undo_err_q <= do_undo & empty;
      if (do_clear)
        led_q <= '0;
      else if (do_undo && !empty)
        led_q <= top;
      else if (do_shift)
        led_q <= {led_q[WIDTH-SYM_W-1:0], bus.din};
    end
  end

  assign bus.led        = led_q;
  assign bus.undo_err   = undo_err_q;
  assign bus.hist_count = count;
  assign bus.hist_empty = empty;
  assign bus.hist_full  = full;
endmodule
